riscv_mc_ctrl: RTL and testbench
================================

RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of wait cycles for a memory acknowledge before trapping.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port instr, input, 32 bits: instruction word; opcode = instr[6:0], captured in DECODE.
REQ-005 The block SHALL have the port branch_taken, input, 1 bit: ALU branch-condition result, sampled in EXEC.
REQ-006 The block SHALL have the port mem_ack, input, 1 bit: memory acknowledge, sampled while mem_req=1.
REQ-007 The block SHALL have the port mem_req, output, 1 bit: memory access request.
REQ-008 The block SHALL have the port mem_is_fetch, output, 1 bit: 1 = instruction fetch, 0 = data access.
REQ-009 The block SHALL have the port mem_we, output, 1 bit: data write (store).
REQ-010 The block SHALL have the port ir_write_en, output, 1 bit: latch the instruction register.
REQ-011 The block SHALL have the port reg_write_en, output, 1 bit: register file write.
REQ-012 The block SHALL have the port wb_sel, output, 1 bit: 0 = ALU result, 1 = memory data.
REQ-013 The block SHALL have the port pc_write_en, output, 1 bit: update the PC.
REQ-014 The block SHALL have the port pc_src, output, 1 bit: 0 = pc+4, 1 = branch target.
REQ-015 The block SHALL have the port state, output, 3 bits: current state (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5).
REQ-016 The block SHALL have the port trap, output, 1 bit: sticky fault flag.
REQ-017 The block SHALL have the port trap_cause, output, 2 bits: 01 = illegal opcode, 10 = fetch timeout, 11 = data timeout.
REQ-018 The block SHALL have the port instret, output, 32 bits: retired-instruction count.

Function
REQ-019 Legal opcodes SHALL be exactly: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
REQ-020 FETCH SHALL assert mem_req=1 and mem_is_fetch=1; on mem_ack=1 it SHALL assert ir_write_en for that cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-021 DECODE SHALL last 1 cycle, register the opcode, and go to EXEC if the opcode is legal; otherwise it SHALL go to TRAP with cause 01.
REQ-022 EXEC SHALL last 1 cycle: BRANCH SHALL assert pc_write_en with pc_src=branch_taken, retire, and go to FETCH; R/I SHALL go to WB; LOAD/STORE SHALL go to MEM.
REQ-023 MEM SHALL assert mem_req=1, mem_is_fetch=0, and mem_we=1 for STORE only, holding all three until mem_ack.
REQ-024 On mem_ack in MEM, LOAD SHALL go to WB; STORE SHALL assert pc_write_en (pc_src=0), retire, and go to FETCH.
REQ-025 WB SHALL last 1 cycle, asserting reg_write_en, wb_sel=1 for LOAD (else 0), and pc_write_en with pc_src=0; it SHALL then retire and go to FETCH.
REQ-026 "Retire" SHALL mean instret increments by 1 on that clock edge; instret SHALL wrap 0xFFFFFFFF -> 0.
REQ-027 Latency with zero-wait ack SHALL be: BRANCH 3 cycles, R/I/STORE 4 cycles, LOAD 5 cycles per instruction.
REQ-028 A wait counter SHALL clear on entry to FETCH or MEM and count each cycle that mem_req=1 and mem_ack=0.
REQ-029 When the wait count reaches TIMEOUT with no ack, the block SHALL go to TRAP with cause 10 (FETCH) or 11 (MEM).
REQ-030 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win: normal transition, no trap.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 TRAP SHALL be absorbing until rst: trap=1, trap_cause held, and mem_req, mem_we, ir_write_en, reg_write_en and pc_write_en all 0.
REQ-033 Every write enable SHALL be high for at most one cycle per instruction, and mem_we SHALL never be 1 while mem_is_fetch=1.

Reset
REQ-034 While rst=1, state SHALL be FETCH and all outputs SHALL be 0, including instret, trap, trap_cause, mem_req and the wait counter.
REQ-035 The first fetch request SHALL appear in the first cycle after rst deasserts.
REQ-036 rst asserted mid-instruction, including during a mem_req wait, SHALL abort it immediately with no retire and no write enable.

Verification
REQ-037 R-type with ack tied high -> state sequence 0,1,2,4; reg_write_en=1 and wb_sel=0 in cycle 4; instret=1.
REQ-038 LOAD with data ack delayed 3 cycles -> MEM lasts 4 cycles; WB has wb_sel=1; total 8 cycles; mem_we=0 throughout.
REQ-039 BRANCH with branch_taken=1, then again with 0 -> pc_write_en in EXEC with pc_src=1, then pc_src=0; reg_write_en stays 0.
REQ-040 Opcode 1111111 -> TRAP after DECODE; trap=1, cause=01; no enables asserted for 20 further cycles.
REQ-041 Fetch ack withheld -> TRAP after exactly TIMEOUT wait cycles with cause 10; ack at the TIMEOUT cycle instead -> DECODE.
REQ-042 rst pulsed during a STORE MEM wait -> outputs 0 and instret unchanged at 0 from the previous reset; fetch resumes the cycle after release.

Source files
------------

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences fetch, decode, execute, memory and
// write-back, counts retired instructions and traps on illegal opcodes or memory timeouts.
module riscv_mc_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        branch_taken,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_is_fetch,
   output logic        mem_we,
   output logic        ir_write_en,
   output logic        reg_write_en,
   output logic        wb_sel,
   output logic        pc_write_en,
   output logic        pc_src,
   output logic [2:0]  state,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t        cur_state;
   state_t        nxt_state;
   logic [1:0]    nxt_cause;
   logic [6:0]    opcode;
   logic [1:0]    cause_q;
   logic [CW-1:0] wait_cnt;
   logic          at_limit;
   logic          is_load;
   logic          is_store;
   logic          instr_unused;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   assign instr_unused = ^instr[31:7];
   assign is_load      = (opcode == OP_LOAD);
   assign is_store     = (opcode == OP_STORE);
   // This is the cycle whose missing ack would make the wait count reach TIMEOUT.
   assign at_limit     = (wait_cnt == CW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_FETCH;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state logic; an ack always wins over a timeout in the same cycle.
   always_comb begin
      nxt_state = cur_state;
      nxt_cause = 2'b00;
      case (cur_state)
         S_FETCH: begin
            if (mem_ack) begin
               nxt_state = S_DECODE;
            end else if (at_limit) begin
               nxt_state = S_TRAP;
               nxt_cause = 2'b10;
            end
         end
         S_DECODE: begin
            if (is_legal(instr[6:0])) begin
               nxt_state = S_EXEC;
            end else begin
               nxt_state = S_TRAP;
               nxt_cause = 2'b01;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_BRANCH:         nxt_state = S_FETCH;
               OP_R, OP_I:        nxt_state = S_WB;
               OP_LOAD, OP_STORE: nxt_state = S_MEM;
               default: begin
                  nxt_state = S_TRAP;
                  nxt_cause = 2'b01;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ack) begin
               nxt_state = is_load ? S_WB : S_FETCH;
            end else if (at_limit) begin
               nxt_state = S_TRAP;
               nxt_cause = 2'b11;
            end
         end
         S_WB:    nxt_state = S_FETCH;
         S_TRAP:  nxt_state = S_TRAP;
         default: nxt_state = S_FETCH;
      endcase
   end

   // Outputs are forced low during reset even though the state reads FETCH.
   always_comb begin
      mem_req      = 1'b0;
      mem_is_fetch = 1'b0;
      mem_we       = 1'b0;
      ir_write_en  = 1'b0;
      reg_write_en = 1'b0;
      wb_sel       = 1'b0;
      pc_write_en  = 1'b0;
      pc_src       = 1'b0;
      if (!rst) begin
         case (cur_state)
            S_FETCH: begin
               mem_req      = 1'b1;
               mem_is_fetch = 1'b1;
               ir_write_en  = mem_ack;
            end
            S_EXEC: begin
               if (opcode == OP_BRANCH) begin
                  pc_write_en = 1'b1;
                  pc_src      = branch_taken;
               end
            end
            S_MEM: begin
               mem_req     = 1'b1;
               mem_we      = is_store;
               pc_write_en = mem_ack && is_store;
            end
            S_WB: begin
               reg_write_en = 1'b1;
               wb_sel       = is_load;
               pc_write_en  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Opcode, trap cause, wait counter and retire counter; every PC write is a retirement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode   <= 7'd0;
         cause_q  <= 2'b00;
         wait_cnt <= '0;
         instret  <= 32'd0;
      end else begin
         if (cur_state == S_DECODE) begin
            opcode <= instr[6:0];
         end
         if (nxt_state == S_TRAP && cur_state != S_TRAP) begin
            cause_q <= nxt_cause;
         end
         if (nxt_state != cur_state) begin
            wait_cnt <= '0;
         end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (pc_write_en) begin
            instret <= instret + 32'd1;
         end
      end
   end

   assign state      = cur_state;
   assign trap       = (cur_state == S_TRAP);
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: a per-instruction reference model predicts each
// retirement or trap, and a monitor compares whenever the DUT retires or traps.
module tb_riscv_mc_ctrl;

   localparam int T = 8;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        branch_taken;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_is_fetch;
   logic        mem_we;
   logic        ir_write_en;
   logic        reg_write_en;
   logic        wb_sel;
   logic        pc_write_en;
   logic        pc_src;
   logic [2:0]  state;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   typedef struct {
      bit          isTrap;
      logic [1:0]  cause;
      bit          pcSrc;
      bit          regWe;
      bit          wbSel;
      bit          isStore;
      int          lat;
      logic [31:0] instret;
   } exp_t;

   exp_t        sb[$];
   int          nTests = 0;
   int          nFail = 0;
   logic [31:0] retired = 0;
   logic [1:0]  heldCause = 0;
   int          cyc = 0;
   int          irCnt = 0;
   int          rwCnt = 0;
   bit          seenTrap = 0;

   riscv_mc_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_is_fetch(mem_is_fetch),
      .mem_we(mem_we), .ir_write_en(ir_write_en), .reg_write_en(reg_write_en),
      .wb_sel(wb_sel), .pc_write_en(pc_write_en), .pc_src(pc_src),
      .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit isLegal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycle count is one per fetch attempt, plus decode and exec,
   // plus memory attempts for loads/stores and one write-back for ALU ops and loads.
   task automatic expectInstr(input logic [6:0] op, input int fw, input int mw, input bit bt);
      exp_t e;
      bit   isMem;
      isMem     = (op == OP_LD) || (op == OP_ST);
      e.isTrap  = 1'b0;
      e.cause   = 2'b00;
      e.pcSrc   = 1'b0;
      e.regWe   = 1'b0;
      e.wbSel   = 1'b0;
      e.isStore = (op == OP_ST);
      e.lat     = 0;
      e.instret = 32'd0;
      if (fw >= T) begin
         e.isTrap = 1'b1; e.cause = 2'b10; e.lat = T;
      end else if (!isLegal(op)) begin
         e.isTrap = 1'b1; e.cause = 2'b01; e.lat = fw + 2;
      end else if (isMem && mw >= T) begin
         e.isTrap = 1'b1; e.cause = 2'b11; e.lat = fw + 3 + T;
      end else begin
         e.lat     = fw + 3 + (isMem ? mw + 1 : 0) + ((op != OP_ST && op != OP_BR) ? 1 : 0);
         e.pcSrc   = (op == OP_BR) && bt;
         e.regWe   = (op == OP_R) || (op == OP_I) || (op == OP_LD);
         e.wbSel   = (op == OP_LD);
         e.instret = retired;
         retired   = retired + 32'd1;
      end
      sb.push_back(e);
   endtask

   task automatic applyReset();
      rst     = 1'b1;
      mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("resetZero",
         {mem_req, mem_is_fetch, mem_we, ir_write_en, reg_write_en, wb_sel,
          pc_write_en, pc_src, state, trap, trap_cause, instret}, 64'd0);
      sb.delete();
      retired = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("fetchAfterReset", {mem_req, mem_is_fetch, mem_we}, 3'b110);
   endtask

   // Drives one instruction: acks a fetch after fw waits and a data access after mw waits,
   // toggles mem_ack randomly when no request is pending, optionally resets mid data wait.
   task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw, input bit bt,
                                input int abortAt, output bit trapped, output bit aborted);
      logic [31:0] r;
      int          phaseWait;
      bit          done;
      r            = $urandom;
      instr        = {r[31:7], op};
      branch_taken = bt;
      trapped      = 1'b0;
      aborted      = 1'b0;
      phaseWait    = 0;
      done         = 1'b0;
      expectInstr(op, fw, mw, bt);
      for (int c = 0; c < 4 * T + 40 && !done; c++) begin
         @(negedge clk);
         if (mem_req) begin
            if (abortAt >= 0 && !mem_is_fetch && phaseWait == abortAt) begin
               mem_ack = 1'b0;
               #2;
               rst = 1'b1;
               #1;
               checkOutput("abortZero",
                  {mem_req, mem_we, ir_write_en, reg_write_en, pc_write_en,
                   trap, trap_cause, state, instret}, 64'd0);
               aborted = 1'b1;
               done    = 1'b1;
            end else begin
               mem_ack = (phaseWait == (mem_is_fetch ? fw : mw));
               phaseWait++;
            end
         end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            phaseWait = 0;
         end
         if (!done) begin
            #1;
            if (pc_write_en) begin
               done = 1'b1;
            end else if (trap) begin
               trapped = 1'b1;
               done    = 1'b1;
            end
         end
      end
      if (!done) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL instrBudget: op %b never retired or trapped", op);
      end
   endtask

   task automatic doInstr(input logic [6:0] op, input int fw, input int mw, input bit bt);
      bit trapped;
      bit aborted;
      applyStimulus(op, fw, mw, bt, -1, trapped, aborted);
      if (trapped) begin
         repeat (20) @(negedge clk);
         applyReset();
      end
   endtask

   // Monitor: compares on every retirement, on trap entry and on every trapped cycle.
   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (rst) begin
         cyc = 0; irCnt = 0; rwCnt = 0; seenTrap = 1'b0;
      end else if (trap) begin
         if (!seenTrap) begin
            seenTrap = 1'b1;
            if (sb.size() == 0) begin
               nTests++; nFail++;
               $display("[TB] FAIL unexpectedTrap: cause %b, none predicted", trap_cause);
            end else begin
               e = sb.pop_front();
               heldCause = e.cause;
               checkOutput("trapCause", {e.isTrap, trap_cause}, {1'b1, e.cause});
               checkOutput("trapLatency", cyc, e.lat);
            end
         end
         checkOutput("trapQuiet",
            {mem_req, mem_we, ir_write_en, reg_write_en, pc_write_en, trap_cause, state},
            {5'b0, heldCause, 3'd5});
      end else begin
         cyc++;
         irCnt += int'(ir_write_en);
         rwCnt += int'(reg_write_en);
         if (mem_is_fetch) checkOutput("fetchNoWe", mem_we, 0);
         if (mem_req && !mem_is_fetch && sb.size() > 0) checkOutput("memWe", mem_we, sb[0].isStore);
         if (reg_write_en && sb.size() > 0) checkOutput("wbSel", wb_sel, sb[0].wbSel);
         if (pc_write_en) begin
            if (sb.size() == 0) begin
               nTests++; nFail++;
               $display("[TB] FAIL unexpectedRetire: instret %0d", instret);
            end else begin
               e = sb.pop_front();
               checkOutput("retireKind", {e.isTrap, pc_src}, {1'b0, e.pcSrc});
               checkOutput("latency", cyc, e.lat);
               checkOutput("irWriteCount", irCnt, 1);
               checkOutput("regWriteCount", rwCnt, e.regWe);
               checkOutput("instret", instret, e.instret);
            end
            cyc = 0; irCnt = 0; rwCnt = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit          trapped;
      bit          aborted;
      int          t;
      int          fw;
      int          mw;
      logic [6:0]  op;
      rst          = 1'b1;
      instr        = 32'd0;
      branch_taken = 1'b0;
      mem_ack      = 1'b0;
      applyReset();

      doInstr(OP_R, 0, 0, 0);
      doInstr(OP_LD, 0, 3, 0);
      doInstr(OP_BR, 0, 0, 1);
      doInstr(OP_BR, 0, 0, 0);
      doInstr(OP_ST, 0, 0, 0);
      doInstr(OP_I, T - 1, 0, 0);
      doInstr(OP_ST, 1, T - 1, 0);

      for (int n = 0; n < 120; n++) begin
         t  = $urandom_range(0, 19);
         fw = ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 3);
         mw = ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 3);
         if (t < 4)       op = OP_R;
         else if (t < 7)  op = OP_I;
         else if (t < 10) op = OP_LD;
         else if (t < 13) op = OP_ST;
         else if (t < 17) op = OP_BR;
         else if (t == 17) begin
            op = OP_R;
            while (isLegal(op)) op = 7'($urandom_range(0, 127));
         end else if (t == 18) begin
            op = OP_I; fw = T;
         end else begin
            op = (($urandom & 1) != 0) ? OP_LD : OP_ST; mw = T;
         end
         doInstr(op, fw, mw, 1'($urandom_range(0, 1)));
      end

      doInstr(7'b1111111, 0, 0, 0);
      doInstr(OP_R, T, 0, 0);
      doInstr(OP_LD, 2, T, 0);

      applyReset();
      applyStimulus(OP_ST, 0, 5, 0, 2, trapped, aborted);
      checkOutput("abortTaken", {trapped, aborted}, 2'b01);
      applyReset();
      doInstr(OP_BR, 0, 0, 1);
      doInstr(OP_LD, 1, 1, 0);

      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      checkOutput("finalInstret", instret, retired);
      checkOutput("scoreboardEmpty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
